// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   XLEN          - machine word width
//   INSTR_NOP     - canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t - {pc, instr} pair carried through the fetch queue
//   word_align    - clears the byte-offset bits of an address
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry in-order FIFO of fetch_entry_t.
//   clk, rst_n  - clock, asynchronous active-low reset (clears contents)
//   push, din   - write din at the tail (ignored when full unless popping)
//   pop         - remove the head (ignored when empty)
//   flush       - discard all entries; wins over push and pop
//   head        - entry at the head (valid when ~empty)
//   count       - occupancy, full, empty
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  // Pop only real entries; a push into a full queue is legal only alongside a pop.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   clk, rst_n               - clock, asynchronous active-low reset
//   imem_addr / imem_rdata   - word-aligned fetch address, combinational read data
//   redirect_valid/_pc       - flush and restart fetch at a new target
//   out_valid/ready/instr/pc - head of the fetch queue toward decode
//   misalign_err             - one-cycle pulse: last redirect target was not word aligned
//   fetch_fault              - PC is outside instruction memory, fetch halted
//   queue_count              - fetch-queue occupancy
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic                       misalign_err,
  output logic                       fetch_fault,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  // One extra bit so IMEM_WORDS*4 == 2^32 still compares correctly.
  localparam logic [XLEN:0] IMEM_LIMIT = {1'b0, 32'(IMEM_WORDS)} << 2;

  function automatic logic pc_in_range(input logic [XLEN-1:0] addr);
    return ({1'b0, addr} < IMEM_LIMIT);
  endfunction

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic            fault_r;
  logic            misalign_r;
  logic            deq_s;
  logic            in_range_s;
  logic            fetch_en_s;
  logic            q_full_s;
  logic            q_empty_s;
  fetch_entry_t    wr_entry_s;
  fetch_entry_t    head_s;

  // Handshake and fetch-enable decode; a redirect suppresses enqueue that cycle.
  always_comb begin
    deq_s      = out_valid & out_ready;
    in_range_s = pc_in_range(pc_r);
    fetch_en_s = ~redirect_valid & in_range_s & (~q_full_s | deq_s);
    wr_entry_s.pc    = pc_r;
    wr_entry_s.instr = imem_rdata;
  end

  // Next PC: redirect wins, otherwise advance only on an actual fetch.
  always_comb begin
    if (redirect_valid) begin
      pc_next_s = word_align(redirect_pc);
    end else if (fetch_en_s) begin
      pc_next_s = pc_r + 32'd4;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC and status registers; fault tracks the PC it will be fetching from next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      fault_r    <= ~pc_in_range(RESET_PC);
      misalign_r <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      fault_r    <= ~pc_in_range(pc_next_s);
      misalign_r <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch_en_s),
    .pop   (deq_s),
    .flush (redirect_valid),
    .din   (wr_entry_s),
    .head  (head_s),
    .count (queue_count),
    .full  (q_full_s),
    .empty (q_empty_s)
  );

  assign imem_addr    = pc_r;
  assign out_valid    = ~q_empty_s;
  assign out_pc       = head_s.pc;
  assign out_instr    = head_s.instr;
  assign misalign_err = misalign_r;
  assign fetch_fault  = fault_r;

endmodule
